seq_detect_param: RTL and testbench

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_param.sv | 87 ++++++++
 tb/tb_seq_detect_param.sv | 118 +++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-loadable N-bit pattern, optional overlap,
// and a saturating match counter. Progress is kept as a KMP-style prefix length.
module seq_detect_param #(
  parameter int             N       = 3,
  parameter logic [N-1:0]   PATTERN = 3'b110,
  parameter int             OVERLAP = 1,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             load,
  input  logic [N-1:0]     pat_in,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     pat_q, pat_nxt;
  logic [SW-1:0]    state, state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             y_nxt, match;

  // Longest proper pattern prefix that is a suffix of (prefix(s) followed by b).
  // prefix(s) is exactly the eligible history, so the pattern alone recovers it.
  function automatic logic [SW-1:0] longest(input logic [N-1:0] p, input int s, input logic b);
    int         best;
    int         idx;
    logic       ok;
    logic       hb;
    logic [N-1:0] t;
    best = 0;
    for (int k = 1; k < N; k++) begin
      if (k <= s + 1) begin
        ok = 1'b1;
        for (int j = 0; j < N - 1; j++) begin
          if (j < k) begin
            idx = s + 1 - k + j;
            t   = p >> (N - 1 - idx);
            hb  = (idx == s) ? b : t[0];
            t   = p >> (N - 1 - j);
            if (hb != t[0]) ok = 1'b0;
          end
        end
        if (ok) best = k;
      end
    end
    return best[SW-1:0];
  endfunction

  assign cnt_sat = &match_cnt;

  always_comb begin
    pat_nxt   = pat_q;
    state_nxt = state;
    cnt_nxt   = match_cnt;
    y_nxt     = 1'b0;
    match     = 1'b0;
    if (load) begin
      pat_nxt   = pat_in;
      state_nxt = '0;
      cnt_nxt   = '0;
    end else if (en) begin
      match = (state == SW'(N - 1)) && (x == pat_q[0]);
      y_nxt = match;
      if (match && (OVERLAP == 0)) state_nxt = '0;
      else                         state_nxt = longest(pat_q, int'(state), x);
      if (match && !cnt_sat) cnt_nxt = match_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q     <= PATTERN;
      state     <= '0;
      y         <= 1'b0;
      match_cnt <= '0;
    end else begin
      pat_q     <= pat_nxt;
      state     <= state_nxt;
      y         <= y_nxt;
      match_cnt <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench: default detector, a non-overlapping twin, and a 2-bit/CNT_W=2 variant.
module tb_seq_detect_param;
  logic       clk = 1'b0;
  logic       rst, en, x, load;
  logic [2:0] pat3;
  logic [1:0] pat2;
  logic       y_a, y_b, y_c, sat_a, sat_b, sat_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.N(3), .PATTERN(3'b110), .OVERLAP(1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat3),
    .y(y_a), .match_cnt(cnt_a), .cnt_sat(sat_a));
  seq_detect_param #(.N(3), .PATTERN(3'b110), .OVERLAP(0), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat3),
    .y(y_b), .match_cnt(cnt_b), .cnt_sat(sat_b));
  seq_detect_param #(.N(2), .PATTERN(2'b11), .OVERLAP(1), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat2),
    .y(y_c), .match_cnt(cnt_c), .cnt_sat(sat_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one edge's inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic xv, input logic ev, input logic lv, input logic rv);
    x = xv; en = ev; load = lv; rst = rv;
    @(posedge clk); #1;
  endtask

  task automatic do_rst();
    step(1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    x = 0; en = 0; load = 0; rst = 1; pat3 = 3'b110; pat2 = 2'b00;
    #2;
    do_rst();
    chk("rst_y",   32'(y_a), 32'(0));
    chk("rst_cnt", 32'(cnt_a), 32'(0));
    chk("rst_sat", 32'(sat_a), 32'(0));
    chk("rst_cnt_c", 32'(cnt_c), 32'(0));

    // Basic 1,1,0 match
    step(1, 1, 0, 0); chk("b1_y", 32'(y_a), 32'(0));
    step(1, 1, 0, 0); chk("b2_y", 32'(y_a), 32'(0));
    step(0, 1, 0, 0); chk("b3_y", 32'(y_a), 32'(1));
    chk("b3_cnt", 32'(cnt_a), 32'(1));
    step(0, 0, 0, 0); chk("b_hold_y", 32'(y_a), 32'(0));
    chk("b_hold_cnt", 32'(cnt_a), 32'(1));

    // Mismatching third 1 keeps state 2
    do_rst();
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0); chk("mm3_y", 32'(y_a), 32'(0));
    step(0, 1, 0, 0); chk("mm4_y", 32'(y_a), 32'(1));
    chk("mm4_cnt", 32'(cnt_a), 32'(1));

    // Hold edges ignore toggling x
    do_rst();
    step(1, 1, 0, 0);
    step(0, 0, 0, 0); chk("h1_y", 32'(y_a), 32'(0));
    step(1, 0, 0, 0); chk("h2_y", 32'(y_a), 32'(0));
    step(0, 0, 0, 0); chk("h3_y", 32'(y_a), 32'(0));
    step(1, 1, 0, 0); chk("h4_y", 32'(y_a), 32'(0));
    step(0, 1, 0, 0); chk("h5_y", 32'(y_a), 32'(1));
    chk("h5_cnt", 32'(cnt_a), 32'(1));

    // Reset mid-pattern discards progress
    do_rst();
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    do_rst();
    step(0, 1, 0, 0); chk("rm_y", 32'(y_a), 32'(0));
    chk("rm_cnt", 32'(cnt_a), 32'(0));

    // Load wins over a completing en/x
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    pat3 = 3'b110;
    step(0, 1, 1, 0); chk("ld_y", 32'(y_a), 32'(0));
    chk("ld_cnt", 32'(cnt_a), 32'(0));
    step(0, 1, 0, 0); chk("ld_next_y", 32'(y_a), 32'(0));

    // Load 101: overlapping (a) vs non-overlapping (b)
    pat3 = 3'b101;
    step(0, 0, 1, 0);
    step(1, 1, 0, 0); chk("ov1_a", 32'(y_a), 32'(0)); chk("ov1_b", 32'(y_b), 32'(0));
    step(0, 1, 0, 0); chk("ov2_a", 32'(y_a), 32'(0)); chk("ov2_b", 32'(y_b), 32'(0));
    step(1, 1, 0, 0); chk("ov3_a", 32'(y_a), 32'(1)); chk("ov3_b", 32'(y_b), 32'(1));
    step(0, 1, 0, 0); chk("ov4_a", 32'(y_a), 32'(0)); chk("ov4_b", 32'(y_b), 32'(0));
    step(1, 1, 0, 0); chk("ov5_a", 32'(y_a), 32'(1)); chk("ov5_b", 32'(y_b), 32'(0));
    chk("ov_cnt_a", 32'(cnt_a), 32'(2));
    chk("ov_cnt_b", 32'(cnt_b), 32'(1));

    // 2-bit all-ones pattern, 2-bit counter saturation
    do_rst();
    for (int e = 1; e <= 6; e++) begin
      step(1, 1, 0, 0);
      chk($sformatf("sat_y%0d", e), 32'(y_c), (e >= 2) ? 32'(1) : 32'(0));
      chk($sformatf("sat_cnt%0d", e), 32'(cnt_c), 32'((e - 1 > 3) ? 3 : e - 1));
    end
    chk("sat_flag", 32'(sat_c), 32'(1));
    chk("sat_flag_a", 32'(sat_a), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
